// File: rtl/seg7_frame_reader.sv
// seg7_frame_reader: recovers hex digits from a multiplexed, active-high
// 7-segment bus (seg_in[0]=a .. seg_in[6]=g, one-hot dig_sel). Each digit
// dwell is glitch-filtered, decoded and stored in a per-digit slot. Once every
// digit has been captured the frame is published (frame_valid) or, if any slot
// held an unrecognised pattern, reported (frame_error + err_mask).

// Per-digit scratch slot: holds the newest capture for one digit until the
// frame it belongs to completes.
module seg7_digit_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic       clr,
    input  logic [3:0] nib_d,
    input  logic       blank_d,
    input  logic       inv_d,
    output logic [3:0] nib,
    output logic       blank,
    output logic       inv,
    output logic       cap
);

    // Clear first, then a same-cycle write wins, so a capture that coincides
    // with frame completion lands in the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            nib   <= 4'h0;
            blank <= 1'b0;
            inv   <= 1'b0;
            cap   <= 1'b0;
        end else begin
            if (clr) begin
                cap <= 1'b0;
                inv <= 1'b0;
            end
            if (wr) begin
                cap   <= 1'b1;
                nib   <= nib_d;
                blank <= blank_d;
                inv   <= inv_d;
            end
        end
    end

endmodule

module seg7_frame_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic [NUM_DIGITS-1:0]   err_mask
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef struct packed {
        logic [NUM_DIGITS-1:0] dig;
        logic [6:0]            seg;
    } bus_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       inv;
    } dec_t;

    // Table literals are written a..g left to right, so the bus is reversed
    // before matching (seg[0] = a ends up in the MSB).
    function automatic dec_t decode(input logic [6:0] s);
        logic [6:0] p;
        dec_t       r;
        p = {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
        r = '{nib: 4'h0, blank: 1'b0, inv: 1'b0};
        case (p)
            7'b1111110: r.nib = 4'h0;
            7'b0110000: r.nib = 4'h1;
            7'b1101101: r.nib = 4'h2;
            7'b1111001: r.nib = 4'h3;
            7'b0110011: r.nib = 4'h4;
            7'b1011011: r.nib = 4'h5;
            7'b1011111: r.nib = 4'h6;
            7'b1110000: r.nib = 4'h7;
            7'b1111111: r.nib = 4'h8;
            7'b1111011: r.nib = 4'h9;
            7'b1110111: r.nib = 4'hA;
            7'b0011111: r.nib = 4'hB;
            7'b1001110: r.nib = 4'hC;
            7'b0111101: r.nib = 4'hD;
            7'b1001111: r.nib = 4'hE;
            7'b1000111: r.nib = 4'hF;
            7'b0000000: r.blank = 1'b1;
            default:    r.inv = 1'b1;
        endcase
        return r;
    endfunction

    bus_t                        sync1, sync2, prev;
    logic [CW-1:0]               cnt, cnt_next;
    logic                        one_hot, changed, capture, complete;
    dec_t                        dec;
    logic [NUM_DIGITS-1:0][3:0]  scr_nib;
    logic [NUM_DIGITS-1:0]       scr_blank, scr_inv, cap_mask;

    // Two-flop synchroniser on the whole bus, plus a copy of the previous
    // synced value for dwell-change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= '{dig: dig_sel, seg: seg_in};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign one_hot = $onehot(sync2.dig);
    assign changed = (sync2 != prev);

    // Dwell length: restarts at 1 on any change, saturates, and is held at 0
    // while the strobe is not a single digit.
    always_comb begin
        cnt_next = cnt;
        if (!one_hot)
            cnt_next = '0;
        else if (changed)
            cnt_next = CW'(1);
        else if (cnt != CNT_MAX)
            cnt_next = cnt + CW'(1);
    end

    // Capture only on the cycle the dwell first reaches the threshold; once
    // saturated the same dwell never captures again.
    assign capture = one_hot && (cnt_next == CNT_MAX) && (changed || (cnt != CNT_MAX));
    assign dec     = decode(sync2.seg);

    // Stability counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_slot
            seg7_digit_slot u_slot (
                .clk     (clk),
                .reset   (reset),
                .wr      (capture && sync2.dig[g]),
                .clr     (complete),
                .nib_d   (dec.nib),
                .blank_d (dec.blank),
                .inv_d   (dec.inv),
                .nib     (scr_nib[g]),
                .blank   (scr_blank[g]),
                .inv     (scr_inv[g]),
                .cap     (cap_mask[g])
            );
        end
    endgenerate

    assign complete = &cap_mask;

    // Publish a finished frame, or report which digits spoiled it; pulses
    // last exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_value <= '0;
            frame_blank <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_mask    <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (complete) begin
                if (|scr_inv) begin
                    frame_error <= 1'b1;
                    err_mask    <= scr_inv;
                end else begin
                    frame_valid <= 1'b1;
                    frame_value <= scr_nib;
                    frame_blank <= scr_blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Bench for seg7_frame_reader: scripted scan table, hand sequences for the
// glitch/strobe/reset corners, then random bus traffic, all compared every
// cycle against a history-based model of the display protocol.
module tb_seg7_frame_reader;

    localparam int ND = 4;
    localparam int S  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel;
    logic [4*ND-1:0] frame_value;
    logic [ND-1:0]   frame_blank;
    logic            frame_valid;
    logic            frame_error;
    logic [ND-1:0]   err_mask;

    always #5 clk = ~clk;

    seg7_frame_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .frame_value (frame_value),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .err_mask    (err_mask)
    );

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int nerror   = 0;

    // Hex glyphs written a..g left to right.
    logic [6:0] ptab [16];

    // Model state
    logic [10:0]           hist [$];   // {dig, seg} driven per cycle
    logic [ND-1:0][3:0]    m_nib;
    logic [ND-1:0]         m_bscr, m_inv, m_mask, m_blk, m_err;
    logic [4*ND-1:0]       m_val;
    logic                  m_pv, m_pe;

    function automatic logic [6:0] pat(input logic [6:0] abcdefg);
        logic [6:0] s;
        for (int i = 0; i < 7; i++) s[i] = abcdefg[6-i];
        return s;
    endfunction

    function automatic logic [6:0] glyph(input int k);
        return pat(ptab[k]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mdec(input logic [6:0] seg, output logic [3:0] nib, output logic bl, output logic inv);
        nib = 4'h0; bl = 1'b0; inv = 1'b0;
        if (seg == 7'd0) bl = 1'b1;
        else begin
            inv = 1'b1;
            for (int k = 0; k < 16; k++)
                if (seg == glyph(k)) begin nib = 4'(k); inv = 1'b0; end
        end
    endtask

    // How many consecutive driven cycles ending at j show the same bus value.
    function automatic int runlen(input int j);
        int r = 1;
        while (j - r >= 0 && r <= S && hist[j-r] == hist[j]) r++;
        return r;
    endfunction

    task automatic model_clear();
        m_nib = '0; m_bscr = '0; m_inv = '0; m_mask = '0;
        m_blk = '0; m_err = '0; m_val = '0; m_pv = 1'b0; m_pe = 1'b0;
    endtask

    // A value driven in cycle j is seen by the capture logic 3 edges later;
    // a dwell is captured when its run reaches exactly S cycles.
    task automatic model_edge(input logic rst);
        int n, j, di;
        logic [10:0] v;
        logic [3:0] nib;
        logic bl, inv;
        n = hist.size() - 1;
        if (rst) begin
            for (int k = 0; k < 3; k++) if (n - k >= 0) hist[n-k] = 11'd0;
            model_clear();
            return;
        end
        m_pv = 1'b0; m_pe = 1'b0;
        if (&m_mask) begin
            if (m_inv == '0) begin m_val = m_nib; m_blk = m_bscr; m_pv = 1'b1; end
            else begin m_err = m_inv; m_pe = 1'b1; end
            m_mask = '0; m_inv = '0;
        end
        j = n - 2;
        if (j >= 0) begin
            v = hist[j];
            if ($onehot(v[10:7]) && runlen(j) == S) begin
                di = 0;
                for (int k = 0; k < ND; k++) if (v[7+k]) di = k;
                mdec(v[6:0], nib, bl, inv);
                m_nib[di] = nib; m_bscr[di] = bl; m_inv[di] = inv; m_mask[di] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic [6:0] seg, input logic [ND-1:0] dig, input logic rst);
        reset = rst; seg_in = seg; dig_sel = dig;
        hist.push_back({dig, seg});
        @(posedge clk);
        model_edge(rst);
        #1;
        chk("frame_value", 32'(frame_value), 32'(m_val));
        chk("frame_blank", 32'(frame_blank), 32'(m_blk));
        chk("frame_valid", 32'(frame_valid), 32'(m_pv));
        chk("frame_error", 32'(frame_error), 32'(m_pe));
        chk("err_mask",    32'(err_mask),    32'(m_err));
        nvalid += int'(frame_valid);
        nerror += int'(frame_error);
    endtask

    task automatic run(input logic [6:0] seg, input logic [ND-1:0] dig, input int n);
        repeat (n) tick(seg, dig, 1'b0);
    endtask

    typedef struct {
        logic [6:0]    p;      // pattern, a..g left to right
        logic [ND-1:0] dig;
        int            hold;
        logic [15:0]   exp_val;
        logic [ND-1:0] exp_blank;
        logic [ND-1:0] exp_err;
        int            exp_nv;
        int            exp_ne;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int nv0, ne0, lat;
        bit found;
        logic [6:0] rs;
        logic [ND-1:0] rd;

        ptab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        // Scan 0,1,2,3; then a frame with an invalid digit 1; then F,b,blank,A
        tbl[0]  = '{7'b1111110, 4'b0001, 8, 16'h0000, 4'b0000, 4'b0000, 0, 0};
        tbl[1]  = '{7'b0110000, 4'b0010, 8, 16'h0000, 4'b0000, 4'b0000, 0, 0};
        tbl[2]  = '{7'b1101101, 4'b0100, 8, 16'h0000, 4'b0000, 4'b0000, 0, 0};
        tbl[3]  = '{7'b1111001, 4'b1000, 8, 16'h3210, 4'b0000, 4'b0000, 1, 0};
        tbl[4]  = '{7'b1111110, 4'b0001, 8, 16'h3210, 4'b0000, 4'b0000, 1, 0};
        tbl[5]  = '{7'b1010101, 4'b0010, 8, 16'h3210, 4'b0000, 4'b0000, 1, 0};
        tbl[6]  = '{7'b1101101, 4'b0100, 8, 16'h3210, 4'b0000, 4'b0000, 1, 0};
        tbl[7]  = '{7'b1111001, 4'b1000, 8, 16'h3210, 4'b0000, 4'b0010, 1, 1};
        tbl[8]  = '{7'b1000111, 4'b0001, 8, 16'h3210, 4'b0000, 4'b0010, 1, 1};
        tbl[9]  = '{7'b0011111, 4'b0010, 8, 16'h3210, 4'b0000, 4'b0010, 1, 1};
        tbl[10] = '{7'b0000000, 4'b0100, 8, 16'h3210, 4'b0000, 4'b0010, 1, 1};
        tbl[11] = '{7'b1110111, 4'b1000, 8, 16'hA0BF, 4'b0100, 4'b0010, 2, 1};

        model_clear();
        tick(7'd0, '0, 1'b1);
        tick(7'd0, '0, 1'b1);
        chk("reset_value", 32'(frame_value), 32'h0);
        chk("reset_blank", 32'(frame_blank), 32'h0);
        chk("reset_err",   32'(err_mask),    32'h0);
        chk("reset_pulses", 32'({frame_valid, frame_error}), 32'h0);

        for (int i = 0; i < 12; i++) begin
            run(pat(tbl[i].p), tbl[i].dig, tbl[i].hold);
            chk($sformatf("tbl%0d_value", i), 32'(frame_value), 32'(tbl[i].exp_val));
            chk($sformatf("tbl%0d_blank", i), 32'(frame_blank), 32'(tbl[i].exp_blank));
            chk($sformatf("tbl%0d_err", i),   32'(err_mask),    32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_nvalid", i), 32'(nvalid), 32'(tbl[i].exp_nv));
            chk($sformatf("tbl%0d_nerror", i), 32'(nerror), 32'(tbl[i].exp_ne));
        end

        // Glitchy digit 0 must not capture; a clean hold then completes the
        // frame exactly S+3 edges after it is first driven.
        nv0 = nvalid;
        run(glyph(1), 4'b0010, 8);
        run(glyph(2), 4'b0100, 8);
        run(glyph(3), 4'b1000, 8);
        for (int k = 0; k < 6; k++) run((k % 2) ? glyph(7) : glyph(4), 4'b0001, 2);
        chk("glitch_no_frame", 32'(nvalid - nv0), 32'd0);
        lat = 0; found = 1'b0;
        for (int t = 1; t <= 20 && !found; t++) begin
            tick(glyph(5), 4'b0001, 1'b0);
            if (frame_valid) begin lat = t; found = 1'b1; end
        end
        chk("capture_latency", 32'(lat), 32'(S + 3));
        run(glyph(5), 4'b0001, 4);
        chk("glitch_value", 32'(frame_value), 32'h3215);

        // Non-one-hot strobes never capture.
        run(glyph(9), 4'b0001, 8);
        run(glyph(8), 4'b0010, 8);
        run(glyph(7), 4'b0100, 8);
        nv0 = nvalid; ne0 = nerror;
        run(glyph(14), 4'b0011, 20);
        run(glyph(14), 4'b0000, 10);
        chk("multi_strobe_no_frame", 32'((nvalid - nv0) + (nerror - ne0)), 32'd0);
        run(glyph(12), 4'b1000, 8);
        chk("strobe_frame_count", 32'(nvalid - nv0), 32'd1);
        chk("strobe_value", 32'(frame_value), 32'hC789);

        // Reset after three captures discards them.
        run(glyph(4), 4'b0001, 8);
        run(glyph(5), 4'b0010, 8);
        run(glyph(6), 4'b0100, 8);
        tick(glyph(6), 4'b0100, 1'b1);
        tick(glyph(6), 4'b0100, 1'b1);
        chk("midreset_value", 32'(frame_value), 32'h0);
        chk("midreset_err",   32'(err_mask),    32'h0);
        nv0 = nvalid; ne0 = nerror;
        run(glyph(11), 4'b1000, 8);
        chk("midreset_no_frame", 32'((nvalid - nv0) + (nerror - ne0)), 32'd0);
        run(glyph(8), 4'b0001, 8);
        run(glyph(9), 4'b0010, 8);
        run(glyph(10), 4'b0100, 8);
        chk("postreset_frames", 32'(nvalid - nv0), 32'd1);
        chk("postreset_value", 32'(frame_value), 32'hBA98);

        // Random bus traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       rs = glyph($urandom_range(0, 15));
            else if (r == 7) rs = 7'd0;
            else             rs = 7'($urandom);
            r = $urandom_range(0, 7);
            if (r < 6)       rd = 4'(1 << $urandom_range(0, ND - 1));
            else if (r == 6) rd = '0;
            else             rd = 4'($urandom);
            if ($urandom_range(0, 59) == 0) tick(rs, rd, 1'b1);
            else run(rs, rd, $urandom_range(1, 7));
        end
        run(7'd0, '0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_frame_reader.md
Name: seg7_frame_reader

Overview:
Receive-side counterpart of the team's hex-to-7-segment decoder. Samples a multiplexed 7-segment display bus (active-high segment pattern plus one-hot digit strobe) and recovers the displayed hex value. Filters glitches, assembles one nibble per digit into a frame, and flags unrecognised segment patterns. Used as a display readback/self-check monitor alongside the segment drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (one strobe bit and one nibble each)
STABLE_CYCLES, 3, consecutive identical synced samples required before a digit is captured (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
seg_in  input  7  segment pattern, index 0 = segment a … index 6 = segment g, 1 = lit
dig_sel  input  NUM_DIGITS  digit strobe, bit i high = digit i currently lit
frame_value  output  4*NUM_DIGITS  last good frame, digit i in bits [4i+3:4i]
frame_blank  output  NUM_DIGITS  bit i high = digit i was blank (all segments off) in last good frame
frame_valid  output  1  one-cycle pulse, frame_value/frame_blank just updated
frame_error  output  1  one-cycle pulse, completed frame contained an invalid pattern
err_mask  output  NUM_DIGITS  digits that held invalid patterns in the last errored frame

Behaviour:
- Reset: all outputs 0; sync registers, stability counter, per-digit captured mask, nibble/blank/invalid scratch registers cleared. Reset mid-frame discards partial frame; no pulse.
- Input sync: seg_in and dig_sel each pass through 2 flops; all logic below uses the second-stage (synced) values.
- Pattern table (segments a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. 0000000 = blank (nibble 0, blank=1). Any other pattern = invalid (nibble 0, invalid=1).
- Stability: counter increments each cycle the synced {seg, dig_sel} equals the previous cycle's value, saturating at STABLE_CYCLES; loads 1 on any change. dig_sel not one-hot (zero or multiple bits) forces counter to 0 and blocks capture.
- Capture: in the cycle the counter reaches STABLE_CYCLES with one-hot dig_sel = bit i, and no capture has yet occurred in this dwell, digit i's nibble/blank/invalid registers are written and captured bit i set. Exactly one capture per dwell; a new dwell starts on any change of synced seg or dig_sel. Recapture of an already-captured digit before frame completion overwrites it (newest wins).
- Frame completion: cycle after captured mask becomes all ones:
  - no invalid digit: frame_value and frame_blank load scratch, frame_valid=1 for one cycle, err_mask unchanged.
  - any invalid digit: frame_value/frame_blank hold, err_mask loads invalid bits, frame_error=1 for one cycle.
  - captured mask and invalid bits clear in the same cycle; frame_valid and frame_error never both high.
- Latency: input pair held stable from before edge k -> capture on edge k+1+STABLE_CYCLES; if that completes the frame, pulse visible after edge k+2+STABLE_CYCLES.
- Capture on the same cycle as completion-clear: new capture lands in the next frame (clear takes effect first, then set).
- Outputs other than pulses hold until next completion or reset.

Test Plan:
- Reset -> all outputs 0; then scan digits 0..3 showing 1111110,0110000,1101101,1111001 (each held 8 cycles) -> frame_valid pulse once, frame_value=16'h3210, frame_blank=0000, frame_error never high.
- Digit 2 shows 0000000, others show F,b,A -> frame_value nibble 2 = 0, frame_blank=0100, frame_valid pulse.
- Digit 1 shows 1010101 (invalid) -> frame_error pulse, err_mask=0010, frame_value keeps prior 16'h3210.
- Glitch: dig_sel=0001 with seg changing every 2 cycles (STABLE_CYCLES=3) -> no capture, no pulse; then held 3+ cycles -> capture occurs, exact latency edge k+1+3.
- dig_sel=0011 held 20 cycles -> no capture; dig_sel=0000 -> no capture.
- Reset asserted after 3 of 4 digits captured -> no pulse; next full scan yields one frame_valid with only post-reset values.
